// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction fetch port
// and a data port. At most one memory transaction is outstanding. Data
// requests normally win; a waiting fetch wins once STARVE_LIMIT data grants
// have gone by while it waited. Protocol violations raise a sticky err flag.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_gnt,
    output logic        imem_rvalid,
    output logic [31:0] imem_rdata,

    input  logic        dmem_req,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_mask,
    output logic        dmem_gnt,
    output logic        dmem_rvalid,
    output logic [31:0] dmem_rdata,

    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        err
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IMEM,
        OWN_DMEM
    } owner_t;

    state_t     state;
    owner_t     owner;
    logic [2:0] starve_cnt;
    logic       err_q;

    logic       arb_active;
    logic       pick_imem;
    logic       accept;
    logic       resp;

    // Grant, memory request and response routing are combinational because
    // the handshake demands same-cycle gnt/rvalid; only control state is held
    // in flops. Every output is forced low while rst is high.
    always_comb begin
        arb_active = (state == IDLE) && !rst;
        pick_imem  = imem_req && (!dmem_req || ({29'd0, starve_cnt} >= STARVE_LIMIT));
        mem_req    = arb_active && (imem_req || dmem_req);
        accept     = mem_req && mem_ready;

        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        if (mem_req) begin
            if (pick_imem) begin
                mem_addr = imem_addr & 32'hFFFF_FFFC;
                mem_mask = 4'b1111;
            end else begin
                mem_wen   = dmem_wen;
                mem_addr  = dmem_addr & 32'hFFFF_FFFC;
                mem_wdata = dmem_wdata;
                mem_mask  = dmem_mask;
            end
        end

        imem_gnt = accept && pick_imem;
        dmem_gnt = accept && !pick_imem;

        resp        = (state == WAIT) && !rst && mem_rvalid;
        imem_rvalid = resp && (owner == OWN_IMEM);
        dmem_rvalid = resp && (owner == OWN_DMEM);
        imem_rdata  = imem_rvalid ? mem_rdata : '0;
        dmem_rdata  = dmem_rvalid ? mem_rdata : '0;

        err = err_q && !rst;
    end

    // Transaction FSM, owner latch, starvation counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_rvalid) begin
                        err_q <= 1'b1;
                    end
                    if (accept) begin
                        state <= WAIT;
                        if (pick_imem) begin
                            owner      <= OWN_IMEM;
                            starve_cnt <= '0;
                        end else begin
                            owner <= OWN_DMEM;
                            if (imem_req && (starve_cnt != 3'd7)) begin
                                starve_cnt <= starve_cnt + 3'd1;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// traffic. Expected responses are queued when a request is issued and a
// negedge monitor pops and compares them whenever the DUT pulses rvalid.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_wen;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_mask(dmem_mask), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    logic [138:0] outs;
    assign outs = {imem_gnt, imem_rvalid, imem_rdata, dmem_gnt, dmem_rvalid, dmem_rdata,
                   mem_req, mem_wen, mem_addr, mem_wdata, mem_mask, err};

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        st;
        logic [31:0] d;
    } dexp_t;

    logic [31:0] exp_i[$];
    dexp_t       exp_d[$];
    logic [31:0] ref_mem[64];
    logic [31:0] dev_mem[64];

    logic mem_en    = 1'b0;
    logic rand_mode = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event expected event within bound", name);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor
    logic [31:0] mon_e;
    dexp_t       mon_de;
    always @(negedge clk) begin
        if (!imem_rvalid) check("imem_rdata_zero", 160'(imem_rdata), 160'(0));
        if (!dmem_rvalid) check("dmem_rdata_zero", 160'(dmem_rdata), 160'(0));
        if (imem_gnt || dmem_gnt) begin
            check("single_gnt", 160'(imem_gnt & dmem_gnt), 160'(0));
            if (imem_gnt)
                check("imem_fields", 160'({mem_req, mem_wen, mem_addr, mem_wdata, mem_mask}),
                      160'({1'b1, 1'b0, imem_addr & 32'hFFFF_FFFC, 32'h0, 4'hF}));
            else
                check("dmem_fields", 160'({mem_req, mem_wen, mem_addr, mem_wdata, mem_mask}),
                      160'({1'b1, dmem_wen, dmem_addr & 32'hFFFF_FFFC, dmem_wdata, dmem_mask}));
        end
        if (imem_rvalid || dmem_rvalid)
            check("single_rvalid", 160'(imem_rvalid & dmem_rvalid), 160'(0));
        if (imem_rvalid) begin
            if (exp_i.size() == 0) fail_note("imem_rvalid_unexpected");
            else begin
                mon_e = exp_i.pop_front();
                check("imem_rdata", 160'(imem_rdata), 160'(mon_e));
            end
        end
        if (dmem_rvalid) begin
            if (exp_d.size() == 0) fail_note("dmem_rvalid_unexpected");
            else begin
                mon_de = exp_d.pop_front();
                if (mon_de.st) check("dmem_ack_rdata", 160'(dmem_rdata), 160'(mem_rdata));
                else           check("dmem_load_rdata", 160'(dmem_rdata), 160'(mon_de.d));
            end
        end
    end

    // Memory device model used in the contention and random phases
    initial begin
        logic        pending;
        int          delay;
        logic [31:0] resp;
        pending = 1'b0;
        delay   = 0;
        resp    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
                if (pending) begin
                    if (delay == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = resp;
                        pending    = 1'b0;
                    end else begin
                        delay--;
                    end
                end
                mem_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(negedge clk);
            if (mem_en && mem_req && mem_ready) begin
                if (mem_wen) begin
                    dev_mem[mem_addr[7:2]] = merge(dev_mem[mem_addr[7:2]], mem_wdata, mem_mask);
                    resp = $urandom;
                end else begin
                    resp = dev_mem[mem_addr[7:2]];
                end
                pending = 1'b1;
                delay   = rand_mode ? int'($urandom_range(0, 2)) : 0;
            end
        end
    end

    task automatic imem_thread();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic        got;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = $urandom;
            a[7] = 1'b0;
            @(posedge clk);
            #1;
            imem_req  = 1'b1;
            imem_addr = a;
            exp_i.push_back(ref_mem[a[7:2]]);
            got = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (imem_gnt) begin got = 1'b1; break; end
            end
            @(posedge clk);
            #1;
            imem_req  = 1'b0;
            imem_addr = '0;
            if (!got) begin fail_note("imem_gnt_timeout"); return; end
            got = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (imem_rvalid) begin got = 1'b1; break; end
            end
            if (!got) begin fail_note("imem_rvalid_timeout"); return; end
        end
    endtask

    task automatic dmem_thread();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic        got;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = $urandom;
            a[7] = 1'b1;
            @(posedge clk);
            #1;
            dmem_req   = 1'b1;
            dmem_addr  = a;
            dmem_wen   = 1'($urandom_range(0, 1));
            dmem_wdata = $urandom;
            dmem_mask  = 4'($urandom_range(1, 15));
            if (dmem_wen) begin
                ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], dmem_wdata, dmem_mask);
                exp_d.push_back({1'b1, 32'h0});
            end else begin
                exp_d.push_back({1'b0, ref_mem[a[7:2]]});
            end
            got = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (dmem_gnt) begin got = 1'b1; break; end
            end
            @(posedge clk);
            #1;
            dmem_req = 1'b0;
            dmem_wen = 1'b0;
            if (!got) begin fail_note("dmem_gnt_timeout"); return; end
            got = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (dmem_rvalid) begin got = 1'b1; break; end
            end
            if (!got) begin fail_note("dmem_rvalid_timeout"); return; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] seq;
        logic [9:0] exp_seq;
        int         ng;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0000;
            dev_mem[i] = ref_mem[i];
        end

        // Reset with hostile inputs: every output must stay low
        rst = 1'b1;
        imem_req = 1'b1; imem_addr = 32'hFFFF_FFFF;
        dmem_req = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'hFFFF_FFFF;
        dmem_wdata = 32'hFFFF_FFFF; dmem_mask = 4'hF;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            cyc();
            smp();
            check("reset_outputs", 160'(outs), 160'(0));
        end
        cyc();
        rst = 1'b0;
        imem_req = 1'b0; imem_addr = '0;
        dmem_req = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_mask = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        smp();
        check("post_reset_idle", 160'(outs), 160'(0));

        // Single fetch, response two cycles after the grant
        cyc();
        imem_req = 1'b1; imem_addr = 32'h0000_0104; mem_ready = 1'b1;
        exp_i.push_back(32'h0010_0093);
        smp();
        check("fetch_gnt_addr", 160'({imem_gnt, dmem_gnt, mem_addr}), 160'({2'b10, 32'h0000_0104}));
        cyc();
        imem_req = 1'b0; imem_addr = '0; mem_ready = 1'b0;
        smp();
        check("wait_outputs_zero", 160'(outs), 160'(0));
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093;
        smp();
        check("fetch_rvalid", 160'({imem_rvalid, dmem_rvalid}), 160'(2'b10));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;

        // Unaligned store; a fetch raised in the ack cycle waits one cycle
        cyc();
        dmem_req = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h0000_2003;
        dmem_wdata = 32'hAB00_0000; dmem_mask = 4'b1000; mem_ready = 1'b1;
        exp_d.push_back({1'b1, 32'h0});
        smp();
        check("store_fields", 160'({dmem_gnt, mem_req, mem_wen, mem_addr, mem_mask}),
              160'({1'b1, 1'b1, 1'b1, 32'h0000_2000, 4'b1000}));
        cyc();
        dmem_req = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_mask = '0;
        imem_req = 1'b1; imem_addr = 32'h0000_0200;
        exp_i.push_back(32'hCAFE_F00D);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        smp();
        check("store_ack_no_gnt", 160'({dmem_rvalid, imem_rvalid, imem_gnt, dmem_rdata}),
              160'({3'b100, 32'hDEAD_BEEF}));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;
        smp();
        check("resume_gnt", 160'({imem_gnt, mem_addr}), 160'({1'b1, 32'h0000_0200}));
        cyc();
        imem_req = 1'b0; imem_addr = '0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        smp();
        check("resume_rvalid", 160'(imem_rvalid), 160'(1));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;

        // Dropped request is forgotten
        cyc();
        dmem_req = 1'b1; dmem_addr = 32'h0000_0044;
        smp();
        check("drop_pending", 160'({mem_req, dmem_gnt}), 160'(2'b10));
        cyc();
        dmem_req = 1'b0; dmem_addr = '0; mem_ready = 1'b1;
        smp();
        check("drop_forgotten", 160'(outs), 160'(0));
        cyc();
        mem_ready = 1'b0;

        // Backpressure: five stalled cycles, grant on the sixth only
        cyc();
        dmem_req = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h0000_3008;
        exp_d.push_back({1'b0, 32'h1234_5678});
        for (int i = 0; i < 5; i++) begin
            smp();
            check("bp_hold", 160'({mem_req, dmem_gnt, mem_wen, mem_addr}),
                  160'({3'b100, 32'h0000_3008}));
            cyc();
        end
        mem_ready = 1'b1;
        smp();
        check("bp_gnt", 160'(dmem_gnt), 160'(1));
        cyc();
        dmem_req = 1'b0; dmem_addr = '0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        smp();
        check("bp_rvalid_single_gnt", 160'({dmem_rvalid, dmem_gnt}), 160'(2'b10));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;

        // Stray response in IDLE raises sticky err
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
        smp();
        check("perr_no_rvalid", 160'({imem_rvalid, dmem_rvalid, err}), 160'(0));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;
        smp();
        check("perr_err_set", 160'(err), 160'(1));
        cyc();
        imem_req = 1'b1; imem_addr = 32'h0000_0108; mem_ready = 1'b1;
        exp_i.push_back(32'h0000_0013);
        smp();
        check("perr_gnt", 160'(imem_gnt), 160'(1));
        cyc();
        imem_req = 1'b0; imem_addr = '0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        smp();
        check("perr_sticky", 160'({imem_rvalid, err}), 160'(2'b11));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;
        smp();
        check("perr_still_set", 160'(err), 160'(1));
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        smp();
        check("err_cleared", 160'(err), 160'(0));

        // Grant and stray response in the same IDLE cycle
        cyc();
        imem_req = 1'b1; imem_addr = 32'h0000_010C; mem_ready = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        exp_i.push_back(32'h0000_0088);
        smp();
        check("gnt_with_rvalid", 160'({imem_gnt, imem_rvalid}), 160'(2'b10));
        cyc();
        imem_req = 1'b0; imem_addr = '0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0088;
        smp();
        check("err_on_gnt_rvalid", 160'({imem_rvalid, err}), 160'(2'b11));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Reset while a transaction is outstanding
        cyc();
        dmem_req = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h0000_4000; mem_ready = 1'b1;
        smp();
        check("mid_gnt", 160'(dmem_gnt), 160'(1));
        cyc();
        dmem_req = 1'b0; dmem_addr = '0; mem_ready = 1'b0;
        rst = 1'b1;
        smp();
        check("mid_rst_outputs", 160'(outs), 160'(0));
        cyc();
        rst = 1'b0;
        smp();
        check("mid_after_rst", 160'(outs), 160'(0));
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
        smp();
        check("stale_no_rvalid", 160'({imem_rvalid, dmem_rvalid}), 160'(0));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;
        imem_req = 1'b1; imem_addr = 32'h0000_0110; mem_ready = 1'b1;
        exp_i.push_back(32'h0000_1111);
        smp();
        check("post_rst_gnt_err", 160'({imem_gnt, err}), 160'(2'b11));
        cyc();
        imem_req = 1'b0; imem_addr = '0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_1111;
        smp();
        check("post_rst_rvalid", 160'(imem_rvalid), 160'(1));
        cyc();
        mem_rvalid = 1'b0; mem_rdata = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Contention with both requests held and 1-cycle memory latency
        @(negedge clk);
        rand_mode = 1'b0;
        mem_en    = 1'b1;
        cyc();
        imem_req = 1'b1; imem_addr = 32'h0000_0010;
        dmem_req = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h0000_0084;
        dmem_wdata = '0; dmem_mask = '0;
        seq = '0;
        ng  = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            smp();
            if (imem_gnt) begin
                seq[ng] = 1'b1;
                exp_i.push_back(ref_mem[4]);
                ng++;
            end else if (dmem_gnt) begin
                seq[ng] = 1'b0;
                exp_d.push_back({1'b0, ref_mem[33]});
                ng++;
            end
        end
        cyc();
        imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_addr = '0;
        repeat (3) cyc();
        check("contention_grants", 160'(ng), 160'(10));
        exp_seq = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++)
            check($sformatf("contention_order_%0d", i), 160'(seq[i]), 160'(exp_seq[i]));
        @(negedge clk);
        mem_en = 1'b0;
        cyc();
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Randomized traffic on both ports
        @(negedge clk);
        rand_mode = 1'b1;
        mem_en    = 1'b1;
        fork
            imem_thread();
            dmem_thread();
        join
        repeat (6) cyc();
        check("imem_queue_drained", 160'(exp_i.size()), 160'(0));
        check("dmem_queue_drained", 160'(exp_d.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive dmem grants after which a waiting imem request takes priority.
REQ-002 SHALL have port clk, input, 1, the rising-edge clock.
REQ-003 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-004 SHALL have ports imem_req (input, 1) and imem_addr (input, 32), an instruction fetch request and its address.
REQ-005 SHALL have ports imem_gnt (output, 1), imem_rvalid (output, 1) and imem_rdata (output, 32): accept strobe, response strobe and fetched word.
REQ-006 SHALL have ports dmem_req (input, 1), dmem_wen (input, 1), dmem_addr (input, 32), dmem_wdata (input, 32) and dmem_mask (input, 4): a data request, write select, address, store data and byte mask.
REQ-007 SHALL have ports dmem_gnt (output, 1), dmem_rvalid (output, 1) and dmem_rdata (output, 32): accept strobe, response strobe (load data or store acknowledge) and load word.
REQ-008 SHALL have ports mem_req (output, 1), mem_wen (output, 1), mem_addr (output, 32), mem_wdata (output, 32) and mem_mask (output, 4), the single shared memory request.
REQ-009 SHALL have ports mem_ready (input, 1), mem_rvalid (input, 1) and mem_rdata (input, 32): memory accept, response strobe and response data.
REQ-010 SHALL have port err (output, 1), a sticky protocol-error flag.

Function
REQ-011 SHALL implement two states: IDLE and WAIT, with at most one outstanding memory transaction.
REQ-012 In IDLE, SHALL select the winner combinationally: dmem when dmem_req=1, except that imem wins when imem_req=1 and starve_cnt>=STARVE_LIMIT.
REQ-013 In IDLE with any request, SHALL drive mem_req=1 and drive the winner's fields onto mem_*, with mem_addr[1:0] forced to 2'b00.
REQ-014 For an imem winner, SHALL drive mem_wen=0, mem_mask=4'b1111 and mem_wdata=0.
REQ-015 In IDLE, SHALL assert the winner's gnt combinationally in the cycle where mem_req&mem_ready=1, latch the owner, and enter WAIT on the next edge.
REQ-016 SHALL never assert imem_gnt and dmem_gnt in the same cycle, and SHALL assert gnt only in IDLE.
REQ-017 In WAIT, SHALL drive mem_req=0 and all other mem_* outputs to 0.
REQ-018 In WAIT with mem_rvalid=1, SHALL pulse the owner's rvalid for that same cycle with rdata=mem_rdata, and return to IDLE on the next edge.
REQ-019 Arbitration SHALL resume in the IDLE cycle after the response; no grant occurs in the response cycle.
REQ-020 For a write ack, dmem_rvalid SHALL pulse and dmem_rdata SHALL equal mem_rdata, value don't-care.
REQ-021 Non-owner rvalid SHALL be 0, and rdata outputs SHALL be 0 whenever their rvalid=0.
REQ-022 starve_cnt (3 bits, saturating at 7):
  - increments on a dmem grant while imem_req=1;
  - clears on any imem grant;
  - holds otherwise.
REQ-023 Requesters SHALL hold req and all request fields stable until gnt; the arbiter does not register request fields.
REQ-024 mem_rvalid=1 in IDLE SHALL be ignored for rvalid purposes and SHALL set err=1; err remains set until rst.
REQ-025 mem_rvalid and mem_ready sampled in the same IDLE cycle SHALL grant normally and also set err.
REQ-026 A request that drops before being granted SHALL be forgotten, with no gnt and no state change.

Reset
REQ-027 On a clk edge with rst=1, SHALL set state=IDLE, starve_cnt=0 and err=0, and clear the latched owner.
REQ-028 While rst=1, SHALL hold all outputs at 0, including mem_req and both gnt signals.
REQ-029 rst asserted during WAIT SHALL abandon the outstanding transaction; a mem_rvalid arriving after reset deassertion sets err and produces no rvalid.

Verification
REQ-030 Single fetch: imem_req=1, addr=0x00000104, mem_ready=1 → imem_gnt pulses and mem_addr=0x00000104; mem_rvalid with rdata=0x00100093 two cycles later → imem_rvalid=1 and imem_rdata=0x00100093.
REQ-031 Unaligned store: dmem_req=1, wen=1, addr=0x00002003, wdata=0xAB000000, mask=4'b1000 → mem_addr=0x00002000, mem_wen=1 and mem_mask=4'b1000; the ack pulses dmem_rvalid.
REQ-032 Contention: imem_req and dmem_req held high continuously with 1-cycle memory latency → grant order D,D,D,D,I,D,D,D,D,I, with no cycle having both gnt signals high.
REQ-033 Backpressure: dmem_req=1 with mem_ready=0 for 5 cycles → mem_req stays 1, dmem_gnt=0 and fields are stable; mem_ready=1 on cycle 6 → dmem_gnt=1 in that cycle only.
REQ-034 Protocol error: mem_rvalid=1 in IDLE → err=1 with no rvalid; err stays 1 through later normal transactions and clears only on rst.
REQ-035 Reset mid-flight: dmem granted, rst=1 for 1 cycle during WAIT → outputs 0 and state IDLE; a new imem_req is then granted normally.
